// File: rtl/muldiv_iter_unit_if.sv
// Issue/result bus between the control unit and the iterative HI/LO mul/div unit.
interface muldiv_iter_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] DA;
    logic [WIDTH-1:0] DB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    // Control unit side: issues ops, observes busy/done and the HI/LO registers.
    modport master (
        output start, op, DA, DB,
        input  busy, done, HI, LO
    );

    // Execution unit side.
    modport slave (
        input  start, op, DA, DB,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/muldiv_iter_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// One shift-add / restoring shift-subtract step per cycle on unsigned magnitudes,
// with the signs applied in a single FIXUP cycle. Latency is fixed at 33 edges.
module muldiv_iter_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_iter_unit_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [ACC_W-1:0]   div_step;

    logic [ACC_W-1:0]   prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   dvd_fix;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    // Operand magnitudes and sign flags captured when an op is issued.
    always_comb begin
        op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_neg     = op_signed && bus.DA[WIDTH-1];
        b_neg     = op_signed && bus.DB[WIDTH-1];
        a_mag     = a_neg ? (~bus.DA + WIDTH'(1)) : bus.DA;
        b_mag     = b_neg ? (~bus.DB + WIDTH'(1)) : bus.DB;
    end

    // One iteration of each datapath; acc low half holds the multiplier / dividend-quotient.
    always_comb begin
        mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : WIDTH'(0))};
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        rem_sh   = acc_q[ACC_W-1:WIDTH-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        div_ok   = ~div_diff[WIDTH];
        div_step = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ok};
    end

    // Sign correction of the finished magnitudes.
    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + ACC_W'(1)) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];
        dvd_fix  = neg_rem_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = bus.op[1];
                            div0_d    = bus.op[1] && (bus.DB == WIDTH'(0));
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            opnd_d    = bus.op[1] ? b_mag : a_mag;
                            acc_d     = {WIDTH'(0), (bus.op[1] ? a_mag : b_mag)};
                            cnt_d     = CNT_W'(0);
                            state_d   = ST_CALC;
                            busy_d    = 1'b1;
                        end
                        OP_MTHI: hi_d = bus.DA;
                        OP_MTLO: lo_d = bus.DA;
                        default: ;
                    endcase
                end
            end

            ST_CALC: begin
                // Divide by zero keeps the dividend untouched but still spends the full count.
                if (!div0_q) begin
                    acc_d = is_div_q ? div_step : mul_step;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIXUP;
                end
            end

            ST_FIXUP: begin
                if (is_div_q) begin
                    if (div0_q) begin
                        hi_d = dvd_fix;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[ACC_W-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Bench for muldiv_iter_unit: directed vector table, corner sequences and random ops
// checked through a scoreboard against an independent arithmetic model.
module tb_muldiv_iter_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_iter_unit_if #(.WIDTH(W)) bus ();
    muldiv_iter_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb_q[$];
    vec_t        vecs[11];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.hi = '0;
        r.lo = '0;
        case (op)
            3'd0: begin sp = sa * sb; r.hi = sp[63:32]; r.lo = sp[31:0]; end
            3'd1: begin up = 64'(a) * 64'(b); r.hi = up[63:32]; r.lo = up[31:0]; end
            3'd2: begin
                if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin sq = sa / sb; sr = sa % sb; r.hi = sr[31:0]; r.lo = sq[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin r.hi = a % b; r.lo = a / b; end
            end
        endcase
        return r;
    endfunction

    // Drive one start at the current negedge; returns at the negedge after edge E0.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        bus.start = 1'b1;
        bus.op    = op;
        bus.DA    = a;
        bus.DB    = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        if (op <= 3'd3) begin
            sb_q.push_back(model(op, a, b));
            check({name, " busy after start"}, 32'(bus.busy), 32'd1);
        end else begin
            if (op == 3'd4) cur_hi = a;
            if (op == 3'd5) cur_lo = a;
            check({name, " busy stays low"}, 32'(bus.busy), 32'd0);
            check({name, " HI"}, bus.HI, cur_hi);
            check({name, " LO"}, bus.LO, cur_lo);
        end
        check({name, " done low after start"}, 32'(bus.done), 32'd0);
    endtask

    // Wait for done (bounded), check latency and HI/LO hold, then score the result.
    task automatic wait_done(input string name, input int already);
        int   k;
        logic found;
        logic hold_ok;
        res_t exp;
        k       = already;
        found   = 1'b0;
        hold_ok = 1'b1;
        while (!found && k < 80) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (bus.done) found = 1'b1;
            else if (bus.HI !== cur_hi || bus.LO !== cur_lo || bus.busy !== 1'b1) hold_ok = 1'b0;
        end
        check({name, " done latency"}, 32'(k), 32'd33);
        check({name, " HI/LO hold while busy"}, 32'(hold_ok), 32'd1);
        if (!found) return;
        check({name, " busy low at done"}, 32'(bus.busy), 32'd0);
        if (sb_q.size() == 0) begin
            check({name, " scoreboard entry present"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check({name, " HI"}, bus.HI, exp.hi);
            check({name, " LO"}, bus.LO, exp.lo);
            cur_hi = exp.hi;
            cur_lo = exp.lo;
        end
    endtask

    initial begin
        int extra_done;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[7]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8]  = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.DA    = '0;
        bus.DB    = '0;
        repeat (3) @(negedge clk);
        check("reset HI", bus.HI, 32'd0);
        check("reset LO", bus.LO, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table; each next op issues in the done cycle of the previous one.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            wait_done($sformatf("vec%0d", i), 0);
            check($sformatf("vec%0d table HI", i), bus.HI, vecs[i].hi);
            check($sformatf("vec%0d table LO", i), bus.LO, vecs[i].lo);
        end
        @(negedge clk);
        check("single done pulse", 32'(bus.done), 32'd0);

        // Start while busy is ignored.
        issue(3'd1, 32'd123456, 32'd789, "busy_ign");
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd3; bus.DA = 32'd1000; bus.DB = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_ign HI held", bus.HI, cur_hi);
        check("busy_ign LO held", bus.LO, cur_lo);
        wait_done("busy_ign", 10);
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra_done++;
        end
        check("busy_ign no second op", 32'(extra_done), 32'd0);
        check("busy_ign scoreboard empty", 32'(sb_q.size()), 32'd0);

        // mthi then mtlo in consecutive idle cycles.
        issue(3'd4, 32'h1234_5678, 32'd0, "mthi");
        issue(3'd5, 32'h9ABC_DEF0, 32'd0, "mtlo");

        // Reserved op leaves everything alone.
        issue(3'd6, 32'hDEAD_BEEF, 32'd1, "reserved");
        repeat (3) @(negedge clk);
        check("reserved no done", 32'(bus.done), 32'd0);

        // Asynchronous reset mid-divide aborts the op.
        issue(3'd2, 32'h0000_1000, 32'd3, "rst_mid");
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid HI", bus.HI, 32'd0);
        check("rst_mid LO", bus.LO, 32'd0);
        check("rst_mid busy", 32'(bus.busy), 32'd0);
        sb_q.delete();
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra_done++;
        end
        check("rst_mid no done", 32'(extra_done), 32'd0);

        // Random ops against the model.
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 6 == 1) rb = 32'd0;
            if (i % 6 == 2) rb = 32'($urandom_range(1, 9));
            if (i % 6 == 3) ra = 32'h8000_0000;
            issue(rop, ra, rb, $sformatf("rnd%0d", i));
            wait_done($sformatf("rnd%0d", i), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
